// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LS chunk first,
// and publishes the result and flags only when the last chunk completes.
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: start is a one-cycle request with no ready; it is taken only
  // while busy is low (IDLE or DONE) and silently dropped while busy is high.

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] acc_next;
  logic             last_chunk;

  // Operands shift right each RUN cycle, so the active chunk is always bit 0;
  // the accumulator fills from the top and is complete after N shifts.
  always_comb begin
    a_chunk    = a_q[CHUNK-1:0];
    b_chunk    = b_q[CHUNK-1:0];
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    acc_next   = (acc_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    last_chunk = (k_q == KW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = input1;
          b_d     = mode ? ~input2 : input2;
          carry_d = mode;
          k_d     = '0;
          acc_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        acc_d   = acc_next;
        carry_d = chunk_sum[CHUNK];
        k_d     = k_q + KW'(1);
        if (last_chunk) begin
          // On the last chunk bit CHUNK-1 of a_q/b_q holds the operand MSBs.
          state_d = S_DONE;
          k_d     = '0;
          out_d   = acc_next;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1]) &&
                    (chunk_sum[CHUNK-1] != a_q[CHUNK-1]);
          zero_d  = (acc_next == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign out       = out_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: three parameterisations, each checked every cycle
// against a cycle-count/arithmetic model, plus directed literal scenarios.
module tb_addsub_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [3];
  logic        start_v [3];
  logic        mode_v  [3];
  logic [31:0] in1_v   [3];
  logic [31:0] in2_v   [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic        cout_w  [3];
  logic        ovf_w   [3];
  logic        zero_w  [3];
  logic [31:0] out_w   [3];

  int n_checks = 0;
  int n_fail   = 0;
  int ops_cnt [3];
  logic [31:0] exp_q[$];

  function automatic void chk(input int g, input string nm,
                              input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL i%0d %s: got 0x%08h, expected 0x%08h", g, nm, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int W = (g == 2) ? 16 : 32;
    localparam int C = (g == 0) ? 8 : ((g == 1) ? 32 : 4);
    localparam int N = W / C;

    logic [W-1:0] o;
    logic [1:0]   st;

    addsub_seq #(.WIDTH(W), .CHUNK(C)) dut (
      .clk       (clk),
      .rst_n     (rst_v[g]),
      .start     (start_v[g]),
      .mode      (mode_v[g]),
      .input1    (in1_v[g][W-1:0]),
      .input2    (in2_v[g][W-1:0]),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .out       (o),
      .carry_out (cout_w[g]),
      .overflow  (ovf_w[g]),
      .zero      (zero_w[g]),
      .dbg_state (st)
    );
    assign out_w[g] = 32'(o);

    // Model: an accepted request finishes N edges later; results are plain
    // modular arithmetic on the masked operands.
    bit valid = 1'b0;
    bit running = 1'b0;
    int run_left = 0;
    logic [31:0] p_out, e_out;
    bit p_c, p_v, p_z, e_c, e_v, e_z, e_busy, e_done;
    longint unsigned ma, mb, mr, mask;

    always @(posedge clk) begin
      mask = (64'd1 << W) - 64'd1;
      if (!rst_v[g]) begin
        valid = 1'b1; running = 1'b0; run_left = 0;
        e_busy = 1'b0; e_done = 1'b0; e_out = '0;
        e_c = 1'b0; e_v = 1'b0; e_z = 1'b0;
      end else begin
        e_done = 1'b0;
        if (running) begin
          run_left--;
          if (run_left == 0) begin
            running = 1'b0;
            e_done = 1'b1;
            e_out = p_out; e_c = p_c; e_v = p_v; e_z = p_z;
            ops_cnt[g]++;
          end
        end else if (start_v[g]) begin
          ma = 64'(in1_v[g]) & mask;
          mb = 64'(in2_v[g]) & mask;
          if (mode_v[g]) begin
            mr  = (ma - mb) & mask;
            p_c = (ma >= mb);
            p_v = (ma[W-1] != mb[W-1]) && (mr[W-1] != ma[W-1]);
          end else begin
            mr  = (ma + mb) & mask;
            p_c = (((ma + mb) >> W) & 64'd1) != 0;
            p_v = (ma[W-1] == mb[W-1]) && (mr[W-1] != ma[W-1]);
          end
          p_out = 32'(mr);
          p_z = (mr == 0);
          running = 1'b1;
          run_left = N;
        end
        e_busy = running;
      end
    end

    always @(negedge clk) begin
      if (valid) begin
        chk(g, "busy",      busy_w[g], e_busy);
        chk(g, "done",      done_w[g], e_done);
        chk(g, "out",       out_w[g],  e_out);
        chk(g, "carry_out", cout_w[g], e_c);
        chk(g, "overflow",  ovf_w[g],  e_v);
        chk(g, "zero",      zero_w[g], e_z);
      end
    end
  end

  // Called at a negedge: the request is sampled on the following posedge.
  task automatic launch(input int g, input bit m, input logic [31:0] a, input logic [31:0] b);
    start_v[g] = 1'b1;
    mode_v[g]  = m;
    in1_v[g]   = a;
    in2_v[g]   = b;
  endtask

  task automatic wait_done(input int g, input int exp_lat, input string nm);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start_v[g] = 1'b0;
    end while (!done_w[g] && lat < 40);
    chk(g, nm, lat, exp_lat);
  endtask

  task automatic chk_res(input int g, input string nm, input logic [31:0] e_out,
                         input bit c, input bit v, input bit z);
    chk(g, {nm, "_out"},  out_w[g],  e_out);
    chk(g, {nm, "_cout"}, cout_w[g], c);
    chk(g, {nm, "_ovf"},  ovf_w[g],  v);
    chk(g, {nm, "_zero"}, zero_w[g], z);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      5: return 32'h0000_8000;
      6: return 32'h0000_7FFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_drive(input int g);
    int cyc = 0;
    ops_cnt[g] = 0;
    while (ops_cnt[g] < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      rst_v[g]   = ($urandom_range(0, 299) != 0);
      start_v[g] = ($urandom_range(0, 3) != 0);
      mode_v[g]  = 1'($urandom_range(0, 1));
      in1_v[g]   = pick();
      in2_v[g]   = pick();
    end
    @(negedge clk);
    rst_v[g]   = 1'b1;
    start_v[g] = 1'b0;
    chk(g, "ops_1000", 32'(ops_cnt[g] >= 1000), 32'd1);
  endtask

  initial begin
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b0; start_v[i] = 1'b0; mode_v[i] = 1'b0;
      in1_v[i] = '0;   in2_v[i] = '0;    ops_cnt[i] = 0;
    end
    start_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    start_v[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk(i, "reset_busy", busy_w[i], 1'b0);
      chk(i, "reset_done", done_w[i], 1'b0);
      chk_res(i, "reset", 32'h0, 1'b0, 1'b0, 1'b0);
      rst_v[i] = 1'b1;
    end
    @(negedge clk);

    launch(0, 1'b1, 32'h0300_1000, 32'h0000_FFFF);
    wait_done(0, 5, "lat_sub");
    chk_res(0, "sub_big", 32'h02FF_1001, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    launch(0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_done(0, 5, "lat_add");
    chk_res(0, "add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    launch(0, 1'b1, 32'h0, 32'h1);
    wait_done(0, 5, "lat_sub01");
    chk_res(0, "sub_0_1", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd990);
    launch(0, 1'b1, 32'd0, 32'd0);
    wait_done(0, 5, "b2b_lat0");
    e = exp_q.pop_front();
    chk_res(0, "b2b0", e, 1'b1, 1'b0, 1'b1);
    launch(0, 1'b1, 32'd10, 32'd0);
    wait_done(0, 5, "b2b_lat1");
    e = exp_q.pop_front();
    chk_res(0, "b2b1", e, 1'b1, 1'b0, 1'b0);
    launch(0, 1'b1, 32'd1000, 32'd10);
    wait_done(0, 5, "b2b_lat2");
    e = exp_q.pop_front();
    chk_res(0, "b2b2", e, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk(0, "b2b_single_pulse", done_w[0], 1'b0);

    launch(0, 1'b1, 32'd1000, 32'd10);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start_v[0] = 1'($urandom_range(0, 1));
      mode_v[0]  = 1'($urandom_range(0, 1));
      in1_v[0]   = $urandom;
      in2_v[0]   = $urandom;
      if (i == 3) begin
        rst_v[0]   = 1'b0;
        start_v[0] = 1'b1;
      end
    end
    @(negedge clk);
    chk(0, "abort_busy", busy_w[0], 1'b0);
    chk(0, "abort_done", done_w[0], 1'b0);
    chk_res(0, "abort", 32'h0, 1'b0, 1'b0, 1'b0);
    rst_v[0]   = 1'b1;
    start_v[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk(0, "abort_no_done", done_w[0], 1'b0);
    end
    launch(0, 1'b1, 32'd1000, 32'd10);
    wait_done(0, 5, "fresh_lat");
    chk_res(0, "fresh", 32'd990, 1'b1, 1'b0, 1'b0);

    fork
      rand_drive(0);
      rand_drive(1);
      rand_drive(2);
    join
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
